// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and default encodings (NOP / HLT opcode) also used by decode.
package fetch_pkg;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  localparam logic [15:0] DEF_NOP_INSTR = 16'h0000;
  localparam logic [3:0]  DEF_HLT_OPC   = 4'hF;

  // HLT detection on the top opcode nibble of a fetched word.
  function automatic logic is_hlt(input logic [3:0] opc, input logic [3:0] hlt_opc);
    return (opc == hlt_opc);
  endfunction

endpackage

// File: rtl/fetch_stats_cnt.sv
// Saturating event counter for fetch statistics; only compiled when FETCH_STATS_EN is defined.
`ifdef FETCH_STATS_EN
module fetch_stats_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Increment on enable, stick at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i && !(&cnt_q)) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule
`endif

// File: rtl/instr_fetch.sv
// Fetch stage: PC, IM read enable, IF/ID register, stall/flush/HLT handling.
// Define FETCH_STATS_EN to add fetch_cnt / bubble_cnt statistics outputs.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int                 ADDR_W    = 16,
  parameter int                 INSTR_W   = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC  = 16'h0000,
  parameter logic [INSTR_W-1:0] NOP_INSTR = DEF_NOP_INSTR,
  parameter logic [3:0]         HLT_OPC   = DEF_HLT_OPC
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_IF,
  input  logic               flow_change,
  input  logic [ADDR_W-1:0]  dst,
  output logic [ADDR_W-1:0]  im_addr,
  output logic               im_rd_en,
  input  logic [INSTR_W-1:0] im_instr,
  output logic [INSTR_W-1:0] instr_IF_ID,
  output logic [ADDR_W-1:0]  pc_IF_ID,
  output logic               valid_IF_ID,
  output logic               halted
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]        fetch_cnt,
  output logic [31:0]        bubble_cnt
`endif
);

  fetch_state_t       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  pcid_q, pcid_d;
  logic               valid_q, valid_d;
  logic               halted_q, halted_d;
  logic               cap_s;
  logic [ADDR_W-1:0]  pc_plus1_s;

  assign pc_plus1_s = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};

  // Next-state: redirect beats stall beats normal capture / halt progression.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pcid_d   = pcid_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    cap_s    = 1'b0;
    if (flow_change) begin
      pc_d     = dst;
      instr_d  = NOP_INSTR;
      valid_d  = 1'b0;
      state_d  = FILL;
      halted_d = 1'b0;
    end else if (stall_IF) begin
      state_d = state_q;
    end else begin
      case (state_q)
        FILL, RUN: begin
          // The read issued on this cycle's negedge is captured here.
          cap_s   = 1'b1;
          instr_d = im_instr;
          pcid_d  = pc_plus1_s;
          valid_d = 1'b1;
          pc_d    = pc_plus1_s;
          if (is_hlt(im_instr[INSTR_W-1 -: 4], HLT_OPC)) begin
            state_d = HALT;
          end else begin
            state_d = RUN;
          end
        end
        HALT: begin
          valid_d  = 1'b0;
          halted_d = 1'b1;
        end
        default: begin
          state_d = FILL;
        end
      endcase
    end
  end

  // Fetch state and IF/ID pipeline register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FILL;
      pc_q     <= RESET_PC;
      instr_q  <= NOP_INSTR;
      pcid_q   <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pcid_q   <= pcid_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

  assign im_addr     = pc_q;
  assign im_rd_en    = flow_change | ((state_q != HALT) & ~stall_IF);
  assign instr_IF_ID = instr_q;
  assign pc_IF_ID    = pcid_q;
  assign valid_IF_ID = valid_q;
  assign halted      = halted_q;

`ifdef FETCH_STATS_EN
  logic bubble_en_s;
  assign bubble_en_s = ~valid_q & (state_q != HALT);

  fetch_stats_cnt #(.W(32)) u_fetch_cnt (
    .clk   (clk),
    .clr_i (rst),
    .en_i  (cap_s),
    .cnt_o (fetch_cnt)
  );

  fetch_stats_cnt #(.W(32)) u_bubble_cnt (
    .clk   (clk),
    .clr_i (rst),
    .en_i  (bubble_en_s),
    .cnt_o (bubble_cnt)
  );
`endif

endmodule
